// File: rtl/gb_pkg.sv
// Shared types and constants for the cartridge ROM SPI reader.
package gb_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  localparam int unsigned SEG_CMD_BITS  = 8;
  localparam int unsigned SEG_ADDR_BITS = 24;
  localparam int unsigned SEG_DATA_BITS = 8;

  typedef logic [23:0] rom_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REOPEN,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD
  } state_e;

  function automatic rom_addr_t addr_inc(input rom_addr_t a);
    return a + 24'd1;
  endfunction

endpackage

// File: rtl/gb_spi_shifter.sv
// CLK_DIV-timed SPI mode-0 bit engine: shifts up to 24 bits out MSB first and
// 8 bits in; a new segment may be chained in the last cycle of the current one.
module gb_spi_shifter
  import gb_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start_i,
  input  logic [4:0]  nbits_i,
  input  logic [23:0] load_i,
  input  logic        miso_i,
  output logic        busy_o,
  output logic        last_o,
  output logic        sck_o,
  output logic        mosi_o,
  output logic [7:0]  rx_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [4:0]       nbits_q, nbits_d;
  logic             busy_q, busy_d;
  logic             sck_q, sck_d;
  logic [23:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             phase_end;

  assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_o    = busy_q && sck_q && phase_end && (bit_q == nbits_q - 5'd1);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path
    // through this block leaves one unassigned (which would infer a latch).
    div_d   = div_q;
    bit_d   = bit_q;
    nbits_d = nbits_q;
    busy_d  = busy_q;
    sck_d   = sck_q;
    tx_d    = tx_q;
    rx_d    = rx_q;

    if (busy_q) begin
      if (phase_end) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[6:0], miso_i};
        end else begin
          sck_d = 1'b0;
          bit_d = bit_q + 5'd1;
          tx_d  = {tx_q[22:0], 1'b0};
          if (last_o) busy_d = 1'b0;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    // Chaining on last_o keeps segments back to back with no idle SCK cell.
    if (start_i && (!busy_q || last_o)) begin
      busy_d  = 1'b1;
      sck_d   = 1'b0;
      div_d   = '0;
      bit_d   = '0;
      nbits_d = nbits_i;
      tx_d    = load_i;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      div_q   <= '0;
      bit_q   <= '0;
      nbits_q <= '0;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      nbits_q <= nbits_d;
      busy_q  <= busy_d;
      sck_q   <= sck_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  assign busy_o = busy_q;
  assign sck_o  = sck_q;
  assign mosi_o = busy_q ? tx_q[23] : 1'b0;
  assign rx_o   = rx_q;

endmodule

// File: rtl/gb_spi_rom_reader.sv
// Cartridge ROM fetcher: issues SPI READ (0x03) per byte and keeps chip-select
// low between sequential addresses so linear fetches stream without a command.
module gb_spi_rom_reader
  import gb_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned CS_HIGH_CYC = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        req,
  input  logic [23:0] addr,
  output logic        ready,
  output logic        valid,
  output logic [7:0]  data,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned REO_W = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;

  state_e          state_q, state_d;
  rom_addr_t       addr_q, addr_d;
  rom_addr_t       next_addr_q, next_addr_d;
  logic            cs_n_q, cs_n_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic [REO_W-1:0] reo_cnt_q, reo_cnt_d;

  logic            sh_start, sh_busy, sh_last, sh_sck, sh_mosi;
  logic [4:0]      sh_nbits;
  logic [23:0]     sh_load;
  logic [7:0]      sh_rx;
  logic            accept;

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign accept = req && ready;

  gb_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clock   (clock),
    .rst     (rst),
    .start_i (sh_start),
    .nbits_i (sh_nbits),
    .load_i  (sh_load),
    .miso_i  (spi_miso),
    .busy_o  (sh_busy),
    .last_o  (sh_last),
    .sck_o   (sh_sck),
    .mosi_o  (sh_mosi),
    .rx_o    (sh_rx)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    cs_n_d      = cs_n_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    reo_cnt_d   = reo_cnt_q;
    sh_start    = 1'b0;
    sh_nbits    = '0;
    sh_load     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = addr;
          cs_n_d  = 1'b0;
          state_d = ST_CMD;
        end
      end
      ST_REOPEN: begin
        if (reo_cnt_q == REO_W'(CS_HIGH_CYC - 1)) begin
          cs_n_d  = 1'b0;
          state_d = ST_CMD;
        end else begin
          reo_cnt_d = reo_cnt_q + REO_W'(1);
        end
      end
      ST_CMD: begin
        if (!sh_busy) begin
          sh_start = 1'b1;
          sh_nbits = 5'(SEG_CMD_BITS);
          sh_load  = {SPI_CMD_READ, 16'h0000};
        end else if (sh_last) begin
          sh_start = 1'b1;
          sh_nbits = 5'(SEG_ADDR_BITS);
          sh_load  = addr_q;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (sh_last) begin
          sh_start = 1'b1;
          sh_nbits = 5'(SEG_DATA_BITS);
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!sh_busy) begin
          sh_start = 1'b1;
          sh_nbits = 5'(SEG_DATA_BITS);
        end else if (sh_last) begin
          valid_d     = 1'b1;
          data_d      = sh_rx;
          next_addr_d = addr_inc(addr_q);
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          addr_d = addr;
          if (addr == next_addr_q) begin
            state_d = ST_DATA;
          end else begin
            cs_n_d    = 1'b1;
            reo_cnt_d = '0;
            state_d   = ST_REOPEN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      next_addr_q <= '0;
      cs_n_q      <= 1'b1;
      valid_q     <= 1'b0;
      data_q      <= '0;
      reo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      cs_n_q      <= cs_n_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      reo_cnt_q   <= reo_cnt_d;
    end
  end

  assign valid    = valid_q;
  assign data     = data_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sck  = sh_sck;
  assign spi_mosi = (state_q != ST_DATA) && sh_mosi;

endmodule

// File: tb/tb_gb_spi_rom_reader.sv
// Randomized scoreboard bench for gb_spi_rom_reader with a behavioural SPI
// NOR flash model and a transaction-level reference for latency and bus shape.
module tb_gb_spi_rom_reader;

  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned CS_HIGH_CYC = 4;
  localparam int LAT_IDLE   = 1 + 80 * CLK_DIV;
  localparam int LAT_SEQ    = 1 + 16 * CLK_DIV;
  localparam int LAT_REOPEN = CS_HIGH_CYC + 1 + 80 * CLK_DIV;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [23:0] addr = '0;
  logic        ready, valid;
  logic [7:0]  data;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso = 1'b0;

  gb_spi_rom_reader #(.CLK_DIV(CLK_DIV), .CS_HIGH_CYC(CS_HIGH_CYC)) dut (
    .clock    (clock),
    .rst      (rst),
    .req      (req),
    .addr     (addr),
    .ready    (ready),
    .valid    (valid),
    .data     (data),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom(input logic [23:0] a);
    if (a == 24'h001234) return 8'hA5;
    if (a == 24'h001235) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h3C;
  endfunction

  // Flash model: READ command, auto-incrementing byte stream while cs_n low.
  int          fl_n = 0;
  int          fl_k;
  logic [31:0] fl_sh = '0;
  logic [7:0]  fl_cmd = '0;
  logic [23:0] fl_addr = '0;
  logic [7:0]  fl_b;
  int          sck_rises = 0;
  int          cs_falls = 0;
  logic        prev_sck = 1'b0;
  logic        prev_cs = 1'b1;

  always @(spi_sck or spi_cs_n) begin
    if (spi_cs_n !== prev_cs) begin
      if (spi_cs_n === 1'b0) cs_falls++;
      fl_n     = 0;
      fl_sh    = '0;
      spi_miso = 1'b0;
    end
    if (spi_sck !== prev_sck) begin
      if (!rst) check("sck_edge_needs_cs_low", {31'd0, spi_cs_n}, 32'd0);
      if (spi_sck === 1'b1) begin
        sck_rises++;
        if (fl_n < 32) fl_sh = {fl_sh[30:0], spi_mosi};
        else check("mosi_zero_in_data", {31'd0, spi_mosi}, 32'd0);
        fl_n++;
        if (fl_n == 32) begin
          fl_cmd  = fl_sh[31:24];
          fl_addr = fl_sh[23:0];
        end
      end else if (fl_n >= 32) begin
        fl_k     = fl_n - 32;
        fl_b     = rom(fl_addr + 24'(fl_k / 8));
        spi_miso = fl_b[7 - (fl_k % 8)];
      end
    end
    prev_sck = spi_sck;
    prev_cs  = spi_cs_n;
  end

  typedef struct {
    logic [23:0] a;
    logic [7:0]  d;
    int lat, sck, csf, csh;
    int acc, sck0, csf0, csh0;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cs_high_n = 0;
  bit          in_hold = 1'b0;
  logic [23:0] nxt = '0;

  // Monitor: pops the oldest expectation whenever the DUT pulses valid.
  always @(negedge clock) begin
    if (spi_cs_n === 1'b1) cs_high_n++;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {31'd0, valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("data", {24'd0, data}, {24'd0, mon_e.d});
        check("latency", cyc - mon_e.acc, mon_e.lat);
        check("sck_pulses", sck_rises - mon_e.sck0, mon_e.sck);
        check("cs_falls", cs_falls - mon_e.csf0, mon_e.csf);
        check("cs_high_clocks", cs_high_n - mon_e.csh0, mon_e.csh);
        check("ready_with_valid", {31'd0, ready}, 32'd1);
        if (mon_e.csf != 0) begin
          check("cmd_byte", {24'd0, fl_cmd}, 32'h03);
          check("addr_bytes", {8'd0, fl_addr}, {8'd0, mon_e.a});
        end
      end
    end
  end

  task automatic do_req(input logic [23:0] a);
    exp_t e;
    int   k;
    k = 0;
    @(negedge clock);
    while (ready !== 1'b1 && k < 1000) begin
      @(negedge clock);
      k++;
    end
    if (ready !== 1'b1) begin
      check("ready_timeout", {31'd0, ready}, 32'd1);
      return;
    end
    e.sck0 = sck_rises;
    e.csf0 = cs_falls;
    req    = 1'b1;
    addr   = a;
    @(posedge clock);
    #1;
    req    = 1'b0;
    addr   = 24'($urandom);
    e.acc  = cyc;
    e.csh0 = cs_high_n;
    e.a    = a;
    e.d    = rom(a);
    if (in_hold && a == nxt) begin
      e.lat = LAT_SEQ;    e.sck = 8;  e.csf = 0; e.csh = 0;
    end else if (in_hold) begin
      e.lat = LAT_REOPEN; e.sck = 40; e.csf = 1; e.csh = CS_HIGH_CYC;
    end else begin
      e.lat = LAT_IDLE;   e.sck = 40; e.csf = 1; e.csh = 0;
    end
    in_hold = 1'b1;
    nxt     = a + 24'd1;
    sb.push_back(e);
    @(negedge clock);
    check("ready_drops", {31'd0, ready}, 32'd0);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (sb.size() != 0) begin
      check("valid_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs_n"},  {31'd0, spi_cs_n}, 32'd1);
    check({tag, "_sck"},   {31'd0, spi_sck},  32'd0);
    check({tag, "_mosi"},  {31'd0, spi_mosi}, 32'd0);
    check({tag, "_ready"}, {31'd0, ready},    32'd1);
    check({tag, "_valid"}, {31'd0, valid},    32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    logic [23:0] a;

    #1 rst = 1'b1;
    #2;
    check_idle_outputs("reset");
    check("reset_data", {24'd0, data}, 32'd0);
    @(negedge clock);
    rst = 1'b0;

    // Directed: first fetch, sequential stream, jump, wrap.
    do_req(24'h001234); wait_done();
    do_req(24'h001235); wait_done();
    do_req(24'h000010); wait_done();
    do_req(24'hFFFFFF); wait_done();
    do_req(24'h000000); wait_done();

    // req pulsed while busy in DATA must be ignored.
    do_req(nxt);
    repeat (6) @(negedge clock);
    req  = 1'b1;
    addr = 24'($urandom);
    check("ready_low_in_data", {31'd0, ready}, 32'd0);
    repeat (3) @(negedge clock);
    req = 1'b0;
    wait_done();
    repeat (40) @(negedge clock);

    // Reset during the ADDR phase, then a formerly sequential address.
    a = nxt;
    base = sck_rises;
    do_req(24'h00ABCD);
    k = 0;
    while (sck_rises - base < 16 && k < 500) begin
      @(negedge clock);
      k++;
    end
    check("reached_addr_phase", {31'd0, (sck_rises - base >= 16)}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    sb.delete();
    in_hold = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    repeat (20) @(negedge clock);
    do_req(a); wait_done();

    // Randomized mix of sequential and arbitrary addresses.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0, 1: a = nxt;
        2:    a = 24'($urandom);
        default: a = 24'hFFFFFE + 24'($urandom_range(0, 1));
      endcase
      do_req(a);
      wait_done();
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end

    repeat (20) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
